// File: rtl/cmd_issue_queue_if.sv
// Producer-side instruction handshake into cmd_issue_queue.
// The producer drives one complete instruction {cmd, d1, d2, d3} with
// in_valid. The queue answers with in_ready.
interface cmd_issue_queue_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_cmd;
  logic [WIDTH-1:0] in_d1;
  logic [WIDTH-1:0] in_d2;
  logic [WIDTH-1:0] in_d3;

  modport master (
    output in_valid,
    output in_cmd,
    output in_d1,
    output in_d2,
    output in_d3,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_cmd,
    input  in_d1,
    input  in_d2,
    input  in_d3,
    output in_ready
  );
endinterface

// File: rtl/cmd_issue_queue.sv
// Command issue queue feeding the CPU top.
// Complete instructions are buffered in a pointer-based FIFO. The head entry
// is presented on cmd_out/dout_1..3 for exactly HOLD_CYCLES cycles. The next
// entry follows back-to-back if one is queued; otherwise the outputs drop to
// NOP (all zero).
// 'count' reports only the entries still waiting in the FIFO. The entry
// currently being issued lives in the output registers and is not counted.
module cmd_issue_queue #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  cmd_issue_queue_if.slave       in_bus,
  output logic [6:0]             cmd_out,
  output logic [WIDTH-1:0]       dout_1,
  output logic [WIDTH-1:0]       dout_2,
  output logic [WIDTH-1:0]       dout_3,
  output logic                   issue_strobe,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = 7 + 3 * WIDTH;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ENT_W-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic [6:0]          cmd_r;
  logic [WIDTH-1:0]    d1_r;
  logic [WIDTH-1:0]    d2_r;
  logic [WIDTH-1:0]    d3_r;
  logic                strobe_r;
  logic                busy_r;
  logic                ready_s;
  logic                push_s;
  logic                pop_s;
  logic                queued_s;
  logic [ENT_W-1:0]    wr_entry_s;
  logic [ENT_W-1:0]    head_s;

  // Ready depends only on the registered occupancy, so accepting a push
  // never depends on a pop happening in the same edge.
  assign ready_s    = (count_r < DEPTH_C);
  assign queued_s   = (count_r != {CNT_W{1'b0}});
  assign push_s     = in_bus.in_valid && ready_s && !flush;
  assign wr_entry_s = {in_bus.in_cmd, in_bus.in_d1, in_bus.in_d2, in_bus.in_d3};
  assign head_s     = mem_r[rd_ptr_r];

  // Next-state and pop decision. A pop uses count_r, so an entry written
  // on this edge cannot be issued on the same edge.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (queued_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (hold_cnt_r == {HOLD_W{1'b0}}) begin
            if (queued_s) begin
              pop_s       = 1'b1;
              state_nxt_s = ST_ISSUE;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_entry_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue registers: load on pop, hold while the window runs, zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_r      <= 7'h00;
      d1_r       <= {WIDTH{1'b0}};
      d2_r       <= {WIDTH{1'b0}};
      d3_r       <= {WIDTH{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
      strobe_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else if (flush) begin
      cmd_r      <= 7'h00;
      d1_r       <= {WIDTH{1'b0}};
      d2_r       <= {WIDTH{1'b0}};
      d3_r       <= {WIDTH{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
      strobe_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else if (pop_s) begin
      cmd_r      <= head_s[ENT_W-1 -: 7];
      d1_r       <= head_s[3*WIDTH-1 -: WIDTH];
      d2_r       <= head_s[2*WIDTH-1 -: WIDTH];
      d3_r       <= head_s[WIDTH-1:0];
      hold_cnt_r <= HOLD_RELOAD;
      strobe_r   <= 1'b1;
      busy_r     <= 1'b1;
    end else if ((state_r == ST_ISSUE) && (hold_cnt_r != {HOLD_W{1'b0}})) begin
      hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
      strobe_r   <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      cmd_r      <= 7'h00;
      d1_r       <= {WIDTH{1'b0}};
      d2_r       <= {WIDTH{1'b0}};
      d3_r       <= {WIDTH{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
      strobe_r   <= 1'b0;
      busy_r     <= 1'b0;
    end
  end

  assign in_bus.in_ready = ready_s;
  assign cmd_out         = cmd_r;
  assign dout_1          = d1_r;
  assign dout_2          = d2_r;
  assign dout_3          = d3_r;
  assign issue_strobe    = strobe_r;
  assign busy            = busy_r;
  assign count           = count_r;

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Directed bench for cmd_issue_queue. It uses three instances that share
// clk/rst:
//   a: HOLD_CYCLES=6 (nominal), l: HOLD_CYCLES=20 (long), c: HOLD_CYCLES=1.
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at the same point.
module tb_cmd_issue_queue;

  logic clk;
  logic rst;
  logic flush_a, flush_l, flush_c;
  int   checks;
  int   errors;

  cmd_issue_queue_if #(.WIDTH(8)) bus_a ();
  cmd_issue_queue_if #(.WIDTH(8)) bus_l ();
  cmd_issue_queue_if #(.WIDTH(8)) bus_c ();

  logic [6:0] cmd_a, cmd_l, cmd_c;
  logic [7:0] d1_a, d2_a, d3_a, d1_l, d2_l, d3_l, d1_c, d2_c, d3_c;
  logic       stb_a, stb_l, stb_c, busy_a, busy_l, busy_c;
  logic [2:0] cnt_a, cnt_l, cnt_c;

  cmd_issue_queue #(.WIDTH(8), .DEPTH(4), .HOLD_CYCLES(6)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .in_bus(bus_a),
    .cmd_out(cmd_a), .dout_1(d1_a), .dout_2(d2_a), .dout_3(d3_a),
    .issue_strobe(stb_a), .busy(busy_a), .count(cnt_a));

  cmd_issue_queue #(.WIDTH(8), .DEPTH(4), .HOLD_CYCLES(20)) dut_l (
    .clk(clk), .rst(rst), .flush(flush_l), .in_bus(bus_l),
    .cmd_out(cmd_l), .dout_1(d1_l), .dout_2(d2_l), .dout_3(d3_l),
    .issue_strobe(stb_l), .busy(busy_l), .count(cnt_l));

  cmd_issue_queue #(.WIDTH(8), .DEPTH(4), .HOLD_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .flush(flush_c), .in_bus(bus_c),
    .cmd_out(cmd_c), .dout_1(d1_c), .dout_2(d2_c), .dout_3(d3_c),
    .issue_strobe(stb_c), .busy(busy_c), .count(cnt_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({cmd_a, d1_a, d2_a, d3_a, stb_a, busy_a, cnt_a} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h expected 0", {cmd_a, d1_a, d2_a, d3_a, stb_a, busy_a, cnt_a});
    end
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b expected 1", bus_a.in_ready);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({stb_a, busy_a, cnt_a, stb_c, busy_c, stb_l, busy_l} !== 9'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %0h expected 0", {stb_a, busy_a, cnt_a, stb_c, busy_c, stb_l, busy_l});
    end
  endtask

  task automatic test_single();
    bus_a.in_valid = 1'b1; bus_a.in_cmd = 7'h05;
    bus_a.in_d1 = 8'h10; bus_a.in_d2 = 8'h03; bus_a.in_d3 = 8'h04;
    step();
    bus_a.in_valid = 1'b0;
    checks++;
    if ({cnt_a, stb_a, cmd_a} !== {3'd1, 1'b0, 7'h00}) begin
      errors++;
      $display("FAIL single_accept: got cnt=%0d stb=%0b cmd=%0h expected cnt=1 stb=0 cmd=0", cnt_a, stb_a, cmd_a);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({cmd_a, d1_a, d2_a, d3_a, busy_a, stb_a} !== {7'h05, 8'h10, 8'h03, 8'h04, 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL single_window cycle %0d: got cmd=%0h d=%0h/%0h/%0h busy=%0b stb=%0b expected 05 10/03/04 busy=1 stb=%0b",
                 i, cmd_a, d1_a, d2_a, d3_a, busy_a, stb_a, (i == 0));
      end
    end
    step();
    checks++;
    if ({cmd_a, d1_a, d2_a, d3_a, busy_a, stb_a} !== 33'd0) begin
      errors++;
      $display("FAIL single_end: got %0h expected 0", {cmd_a, d1_a, d2_a, d3_a, busy_a, stb_a});
    end
  endtask

  task automatic test_back_to_back();
    int se [4];
    logic [6:0] sc [4];
    logic [2:0] sn [4];
    int n = 0;
    int gap = 0;
    for (int e = 0; e <= 24; e++) begin
      bus_a.in_valid = (e < 3);
      bus_a.in_cmd = 7'h11 + 7'(e); bus_a.in_d1 = 8'hA0 + 8'(e);
      bus_a.in_d2 = 8'h00; bus_a.in_d3 = 8'h00;
      step();
      if (stb_a === 1'b1 && n < 4) begin
        se[n] = e; sc[n] = cmd_a; sn[n] = cnt_a; n++;
      end
      if (e >= 1 && e <= 18 && busy_a !== 1'b1) gap++;
    end
    bus_a.in_valid = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL b2b_strobe_count: got %0d expected 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (se[i] !== 1 + 6 * i || sc[i] !== 7'h11 + 7'(i)) begin
          errors++;
          $display("FAIL b2b_issue %0d: got edge=%0d cmd=%0h expected edge=%0d cmd=%0h", i, se[i], sc[i], 1 + 6 * i, 7'h11 + 7'(i));
        end
      end
      checks++;
      if ({sn[0], sn[1], sn[2]} !== {3'd1, 3'd1, 3'd0}) begin
        errors++;
        $display("FAIL b2b_counts: got %0d,%0d,%0d expected 1,1,0", sn[0], sn[1], sn[2]);
      end
    end
    checks++;
    if (gap !== 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: got gaps=%0d final busy=%0b expected 0 and 0", gap, busy_a);
    end
  endtask

  task automatic test_full();
    int acc [6];
    int iss [8];
    int iss_e0 = -1;
    int k = 0;
    int ni = 0;
    logic hs;
    bus_l.in_valid = 1'b1; bus_l.in_cmd = 7'h40; bus_l.in_d1 = 8'd1;
    bus_l.in_d2 = 8'h00; bus_l.in_d3 = 8'h00;
    for (int e = 0; e <= 130; e++) begin
      hs = bus_l.in_valid && bus_l.in_ready;
      step();
      if (hs) begin
        acc[k] = e; k++;
        if (k < 6) begin
          bus_l.in_cmd = 7'h40 + 7'(k); bus_l.in_d1 = 8'(k + 1);
        end else begin
          bus_l.in_valid = 1'b0;
        end
      end
      if (stb_l === 1'b1) begin
        if (ni == 0) iss_e0 = e;
        if (ni < 8) iss[ni] = int'(d1_l);
        ni++;
      end
      if (e == 4 || e == 20) begin
        checks++;
        if (cnt_l !== 3'd4 || bus_l.in_ready !== 1'b0 || k !== 5) begin
          errors++;
          $display("FAIL full_state edge %0d: got cnt=%0d ready=%0b accepted=%0d expected 4 0 5", e, cnt_l, bus_l.in_ready, k);
        end
      end
    end
    checks++;
    if (k !== 6 || acc[1] !== 1 || acc[4] !== 4 || acc[5] !== 22) begin
      errors++;
      $display("FAIL full_accept: got n=%0d e1=%0d e4=%0d e5=%0d expected 6 1 4 22", k, acc[1], acc[4], acc[5]);
    end
    checks++;
    if (iss_e0 !== 1) begin
      errors++;
      $display("FAIL full_first_pop: got edge %0d expected 1", iss_e0);
    end
    checks++;
    if (ni !== 6) begin
      errors++;
      $display("FAIL full_issue_count: got %0d expected 6", ni);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (iss[i] !== i + 1) begin
          errors++;
          $display("FAIL full_order %0d: got %0d expected %0d", i, iss[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    bus_a.in_d2 = 8'h00; bus_a.in_d3 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      bus_a.in_valid = 1'b1; bus_a.in_cmd = 7'h21 + 7'(i); bus_a.in_d1 = 8'(i);
      step();
    end
    bus_a.in_valid = 1'b0;
    step();
    checks++;
    if ({cnt_a, busy_a, cmd_a} !== {3'd2, 1'b1, 7'h21}) begin
      errors++;
      $display("FAIL flush_pre: got cnt=%0d busy=%0b cmd=%0h expected 2 1 21", cnt_a, busy_a, cmd_a);
    end
    flush_a = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.in_cmd = 7'h7F; bus_a.in_d1 = 8'hEE;
    step();
    flush_a = 1'b0;
    bus_a.in_valid = 1'b0;
    checks++;
    if ({cmd_a, d1_a, d2_a, d3_a, cnt_a, busy_a, stb_a} !== 36'd0) begin
      errors++;
      $display("FAIL flush_clear: got %0h expected 0", {cmd_a, d1_a, d2_a, d3_a, cnt_a, busy_a, stb_a});
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if (stb_a === 1'b1 || busy_a === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_no_issue: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    bus_a.in_valid = 1'b1; bus_a.in_cmd = 7'h33; bus_a.in_d1 = 8'h55;
    step();
    bus_a.in_valid = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cmd_a, d1_a, busy_a, cnt_a} !== 19'd0) begin
      errors++;
      $display("FAIL rst_async: got cmd=%0h d1=%0h busy=%0b cnt=%0d expected all 0", cmd_a, d1_a, busy_a, cnt_a);
    end
    step(); step();
    rst = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_cmd = 7'h44; bus_a.in_d1 = 8'h66;
    step();
    bus_a.in_valid = 1'b0;
    step();
    checks++;
    if ({stb_a, busy_a, cmd_a, d1_a} !== {1'b1, 1'b1, 7'h44, 8'h66}) begin
      errors++;
      $display("FAIL rst_reissue: got stb=%0b busy=%0b cmd=%0h d1=%0h expected 1 1 44 66", stb_a, busy_a, cmd_a, d1_a);
    end
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_reissue_end: got busy=%0b expected 0", busy_a);
    end
  endtask

  task automatic test_wrap();
    int ia [12];
    int ea [12];
    int ic [12];
    int ec [12];
    int na = 0;
    int nc = 0;
    int ka = 0;
    int kc = 0;
    int max_cnt = 0;
    logic hs;
    bus_a.in_valid = 1'b1; bus_a.in_cmd = 7'h50; bus_a.in_d1 = 8'd0;
    for (int e = 0; e <= 75; e++) begin
      hs = bus_a.in_valid && bus_a.in_ready;
      step();
      if (hs) begin
        ka++;
        if (ka < 11) bus_a.in_d1 = 8'(ka);
        else bus_a.in_valid = 1'b0;
      end
      if (int'(cnt_a) > max_cnt) max_cnt = int'(cnt_a);
      if (stb_a === 1'b1) begin
        if (na < 12) begin ia[na] = int'(d1_a); ea[na] = e; end
        na++;
      end
    end
    checks++;
    if (na !== 11 || max_cnt !== 4) begin
      errors++;
      $display("FAIL wrap6_count: got issues=%0d maxcnt=%0d expected 11 4", na, max_cnt);
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (ia[i] !== i || ea[i] !== 1 + 6 * i) begin
          errors++;
          $display("FAIL wrap6_issue %0d: got d1=%0d edge=%0d expected %0d %0d", i, ia[i], ea[i], i, 1 + 6 * i);
        end
      end
    end
    bus_c.in_valid = 1'b1; bus_c.in_cmd = 7'h60; bus_c.in_d1 = 8'd0;
    bus_c.in_d2 = 8'h00; bus_c.in_d3 = 8'h00;
    for (int e = 0; e <= 16; e++) begin
      hs = bus_c.in_valid && bus_c.in_ready;
      step();
      if (hs) begin
        kc++;
        if (kc < 11) bus_c.in_d1 = 8'(kc);
        else bus_c.in_valid = 1'b0;
      end
      if (stb_c === 1'b1) begin
        if (nc < 12) begin ic[nc] = int'(d1_c); ec[nc] = e; end
        nc++;
      end
    end
    checks++;
    if (nc !== 11 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL wrap1_count: got issues=%0d busy=%0b expected 11 0", nc, busy_c);
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (ic[i] !== i || ec[i] !== 1 + i) begin
          errors++;
          $display("FAIL wrap1_issue %0d: got d1=%0d edge=%0d expected %0d %0d", i, ic[i], ec[i], i, 1 + i);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush_a = 1'b0; flush_l = 1'b0; flush_c = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_cmd = 7'h00; bus_a.in_d1 = 8'h00; bus_a.in_d2 = 8'h00; bus_a.in_d3 = 8'h00;
    bus_l.in_valid = 1'b0; bus_l.in_cmd = 7'h00; bus_l.in_d1 = 8'h00; bus_l.in_d2 = 8'h00; bus_l.in_d3 = 8'h00;
    bus_c.in_valid = 1'b0; bus_c.in_cmd = 7'h00; bus_c.in_d1 = 8'h00; bus_c.in_d2 = 8'h00; bus_c.in_d3 = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
